// File: rtl/reg_file_scoreboard_pkg.sv
// reg_file_scoreboard_pkg: shared widths, register-ID types and the one-hot test
package reg_file_scoreboard_pkg;
    localparam int REG_ID_W = 4;
    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 16;
    typedef logic [REG_ID_W-1:0] reg_id_t;
    typedef logic [DATA_W-1:0]   data_t;
    localparam reg_id_t ZERO_REG = 4'd0;
    // True only when exactly one bit is set; an all-zero wordline is "no write", not one-hot
    function automatic logic is_onehot16(input logic [NUM_REGS-1:0] v);
        return (v != '0) && ((v & (v - 16'd1)) == '0);
    endfunction
endpackage

// File: rtl/reg_file_scoreboard_if.sv
// reg_file_scoreboard_if: decode/writeback bundle into the register file
interface reg_file_scoreboard_if;
    import reg_file_scoreboard_pkg::*;
    logic [NUM_REGS-1:0] Wordline;
    data_t               WriteData;
    reg_id_t             SrcReg1;
    reg_id_t             SrcReg2;
    logic                Use1;
    logic                Use2;
    logic                IssueValid;
    reg_id_t             IssueDst;
    data_t               SrcData1;
    data_t               SrcData2;
    logic                Stall;
    logic                WordlineErr;
    modport master (
        output Wordline, WriteData, SrcReg1, SrcReg2, Use1, Use2, IssueValid, IssueDst,
        input  SrcData1, SrcData2, Stall, WordlineErr
    );
    modport slave (
        input  Wordline, WriteData, SrcReg1, SrcReg2, Use1, Use2, IssueValid, IssueDst,
        output SrcData1, SrcData2, Stall, WordlineErr
    );
endinterface

// File: rtl/reg_file_scoreboard_pending_scoreboard.sv
// pending_scoreboard: per-register in-flight bits and the RAW stall they cause
module pending_scoreboard
    import reg_file_scoreboard_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_REGS-1:0] wordline,
    input  logic                onehot,
    input  logic                issue_valid,
    input  reg_id_t             issue_dst,
    input  reg_id_t             src1,
    input  reg_id_t             src2,
    input  logic                use1,
    input  logic                use2,
    output logic                stall
);
    logic [NUM_REGS-1:0] pending_q, pending_d;

    // A source is hazardous only if pending and not being written back right now (bypass covers that)
    function automatic logic hz(input logic [NUM_REGS-1:0] p, input logic [NUM_REGS-1:0] wl,
                                input logic oh, input reg_id_t r);
        return p[r] && !(wl[r] && oh) && (r != ZERO_REG);
    endfunction

    assign stall = (use1 && hz(pending_q, wordline, onehot, src1)) ||
                   (use2 && hz(pending_q, wordline, onehot, src2));

    // Clear on writeback first, then set on issue so a new producer to the same register wins
    always_comb begin
        pending_d = pending_q;
        if (onehot) pending_d = pending_d & ~wordline;
        if (issue_valid && !stall && issue_dst != ZERO_REG) pending_d[issue_dst] = 1'b1;
        pending_d[0] = 1'b0;
    end

    // Pending bit register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending_q <= '0;
        else        pending_q <= pending_d;
    end
endmodule

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: 16x16 register file with one-hot write wordline, bypass and RAW scoreboard
module reg_file_scoreboard
    import reg_file_scoreboard_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    reg_file_scoreboard_if.slave  bus
);
    data_t regs_q [NUM_REGS];
    data_t regs_d [NUM_REGS];
    logic  err_q, err_d;
    logic  onehot;

    assign onehot = is_onehot16(bus.Wordline);

    assign bus.SrcData1 = (bus.SrcReg1 == ZERO_REG) ? '0 :
                          (bus.Wordline[bus.SrcReg1] && onehot) ? bus.WriteData : regs_q[bus.SrcReg1];
    assign bus.SrcData2 = (bus.SrcReg2 == ZERO_REG) ? '0 :
                          (bus.Wordline[bus.SrcReg2] && onehot) ? bus.WriteData : regs_q[bus.SrcReg2];
    assign bus.WordlineErr = err_q;

    // Write the single selected register; multi-hot writes nothing and latches the error flag
    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < NUM_REGS; i++)
            if (onehot && bus.Wordline[i]) regs_d[i] = bus.WriteData;
        regs_d[0] = '0;
        err_d = err_q | ((bus.Wordline != '0) && !onehot);
    end

    // Register array and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            err_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            err_q  <= err_d;
        end
    end

    pending_scoreboard u_pending (
        .clk         (clk),
        .rst_n       (rst_n),
        .wordline    (bus.Wordline),
        .onehot      (onehot),
        .issue_valid (bus.IssueValid),
        .issue_dst   (bus.IssueDst),
        .src1        (bus.SrcReg1),
        .src2        (bus.SrcReg2),
        .use1        (bus.Use1),
        .use2        (bus.Use2),
        .stall       (bus.Stall)
    );
endmodule

// File: doc/reg_file_scoreboard.md
Name: reg_file_scoreboard

Overview:
16-entry x 16-bit architectural register file that directly consumes the 4-to-16 one-hot write wordline produced by the write-decode stage.
- One write port, two read ports, with same-cycle write-to-read bypass.
- Per-register pending scoreboard: decode stage marks destinations of in-flight instructions; writeback clears them.
- Outputs a Stall for RAW hazards on not-yet-written sources.
- Sits between decode (read/issue) and writeback (write/clear).

Parameters:
DATA_W, 16, register width in bits
NUM_REGS, 16, register count; fixed at 16 to match 4-bit register IDs and the 16-bit wordline

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
Wordline  input  16  one-hot write select from write decoder; all-zero = no write
WriteData  input  16  writeback data
SrcReg1  input  4  read port 1 register ID
SrcReg2  input  4  read port 2 register ID
Use1  input  1  SrcReg1 is a real operand (enables hazard check)
Use2  input  1  SrcReg2 is a real operand
IssueValid  input  1  decode issues an instruction with a register destination
IssueDst  input  4  destination register of issuing instruction
SrcData1  output  16  read data port 1
SrcData2  output  16  read data port 2
Stall  output  1  RAW hazard; decode must hold
WordlineErr  output  1  sticky flag: Wordline seen with more than one bit set

Behaviour:
- Reset (rst_n=0, async): all registers = 0; pending[15:0] = 0; WordlineErr = 0. Consequently SrcData1/2 = 0 and Stall = 0 while in reset.
- Write: on posedge clk, reg[i] <= WriteData for the single i with Wordline[i]=1.
  - Wordline[0] is ignored: R0 is hardwired 0.
  - Multi-hot Wordline: no register is written and WordlineErr sets; it stays set until reset.
- Read: combinational, zero latency.
  - SrcDataN = 0 if SrcRegN==0.
  - Otherwise, if Wordline[SrcRegN]=1 and Wordline is one-hot, SrcDataN = WriteData (bypass).
  - Otherwise SrcDataN = reg[SrcRegN].
- Scoreboard set: at posedge, if IssueValid && !Stall && IssueDst!=0, then pending[IssueDst] <= 1. Issue while Stall=1 is ignored.
- Scoreboard clear: at posedge, pending[i] <= 0 for a one-hot Wordline bit i.
- Same-cycle issue and writeback to the same register: set wins and pending stays 1, because the new producer is now outstanding.
- Stall (combinational) = (Use1 && hz(SrcReg1)) || (Use2 && hz(SrcReg2)).
  - hz(r) = pending[r] && !(Wordline[r] && one-hot) && r!=0.
  - A writeback arriving this cycle resolves the hazard via the bypass, so no stall.
- IssueDst equal to a source register does not stall by itself; only pending sources stall.
- pending[0] is never set.
- Reset mid-operation: everything is cleared asynchronously. In-flight writebacks after reset still write normally; their clears hit pending bits that are already 0 and are harmless.
- Timing: write-to-register latency is 1 cycle; bypass gives effective read-after-write latency of 0.

Decomposition:
- Shared package holds:
  - REG_ID_W=4, DATA_W=16, NUM_REGS=16
  - ZERO_REG=4'd0
  - function is_onehot16
- One natural sub-module: pending_scoreboard. It owns the pending bits, set/clear priority and the hz() logic, and is instantiated once.
- The data array and bypass muxes stay in the top.

Test Plan:
- Reset, then read R1..R15 -> SrcData1/2 = 0x0000, Stall=0, WordlineErr=0.
- Wordline=0x0008, WriteData=0xBEEF with SrcReg1=3 the same cycle -> SrcData1=0xBEEF (bypass). Next cycle, with Wordline=0 -> SrcData1=0xBEEF from storage.
- Wordline=0x0001, WriteData=0x1234 -> R0 reads 0x0000; SrcReg1=0 never stalls.
- IssueValid=1, IssueDst=5. Next cycle SrcReg2=5, Use2=1 -> Stall=1. Then Wordline=0x0020, WriteData=0x00A5 -> Stall=0 that cycle and SrcData2=0x00A5.
- Same cycle IssueValid=1, IssueDst=7, Wordline=0x0080 -> next cycle pending[7]=1, Stall=1 when SrcReg1=7, Use1=1.
- Wordline=0x0006 (multi-hot) -> no write to R1/R2, WordlineErr=1 and sticky. Assert rst_n low mid-stall -> Stall=0, WordlineErr=0 and all regs 0 immediately.
